// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Receives fixed-length frames from an external serial clock/data pair that is
// asynchronous to clk. Both pins are synchronised, rising edges of the
// synchronised serial clock shift data in MSB first, and a completed frame
// updates the channel index / value outputs with a one-cycle strobe. A partial
// frame whose serial clock stops for TIMEOUT_CYCLES clk cycles is dropped with
// an error strobe.
//
// Frame layout (MSB first on the wire):
//   bits 16..11  channel index
//   bits 10..0   channel value
//   bit  17      even parity over bits 16..0 (only with SERIAL_FRAME_PARITY_EN)
//
// Optional feature macro: SERIAL_FRAME_PARITY_EN
//   defined   -> 18-bit frames; a parity mismatch gives frame_err and the
//                outputs keep their previous value.
//   undefined -> 17-bit frames, no parity logic.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth for sClk and serialIn (2..4)
//   TIMEOUT_CYCLES  clk cycles without a serial clock edge before a partial
//                   frame is aborted
//
// Ports:
//   clk           system clock, all state updates on its rising edge
//   rst           synchronous active-high reset
//   sClk          external serial clock (asynchronous)
//   serialIn      external serial data, valid on sClk rising edge (asynchronous)
//   dataIn        value of the last good frame
//   dataInChange  channel index of the last good frame
//   frame_valid   one-cycle strobe: dataIn / dataInChange just updated
//   frame_err     one-cycle strobe: frame aborted (timeout) or rejected
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sClk,
  input  logic        serialIn,
  output logic [10:0] dataIn,
  output logic [5:0]  dataInChange,
  output logic        frame_valid,
  output logic        frame_err
);

`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FRAME_W = 18;
`else
  localparam int FRAME_W = 17;
`endif
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Timeout counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TO_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sin_sync_q, sin_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;

  logic                   edge_stb, sin_s, last_bit, timeout;
  state_t                 state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // Holds the bits received so far; the final bit is taken straight from the
  // synchroniser so the decoded frame is registered on the edge that samples it.
  logic [FRAME_W-2:0]     sreg_q, sreg_d;
  logic [FRAME_W-1:0]     frame;
  logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic [10:0]            data_q, data_d;
  logic [5:0]             chan_q, chan_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // ---- synchroniser stage: raw pins enter here only ----
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sClk};
    sin_sync_d  = {sin_sync_q[SYNC_STAGES-2:0], serialIn};
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sin_sync_q  <= sin_sync_d;
      sclk_dly_q  <= sclk_dly_d;
    end
  end

  // ---- edge detect / frame decode stage ----
  assign edge_stb = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
  assign sin_s    = sin_sync_q[SYNC_STAGES-1];
  assign frame    = {sreg_q, sin_s};
  assign last_bit = edge_stb && (bit_cnt_q == LAST_BIT);
  // An edge in the final timeout cycle takes priority, hence !edge_stb.
  assign timeout  = (state_q == SHIFT) && !edge_stb && (to_cnt_q == TO_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_stb) state_d = SHIFT;
      SHIFT:   if (last_bit || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    chan_d    = chan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (edge_stb) begin
      sreg_d   = frame[FRAME_W-2:0];
      to_cnt_d = '0;
      if (last_bit) begin
        bit_cnt_d = '0;
`ifdef SERIAL_FRAME_PARITY_EN
        if (^frame) begin
          err_d = 1'b1;
        end else begin
          chan_d  = frame[16:11];
          data_d  = frame[10:0];
          valid_d = 1'b1;
        end
`else
        chan_d  = frame[16:11];
        data_d  = frame[10:0];
        valid_d = 1'b1;
`endif
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end else if (state_q == SHIFT) begin
      if (timeout) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = sat_inc(to_cnt_q);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      chan_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign dataIn       = data_q;
  assign dataInChange = chan_q;
  assign frame_valid  = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Bench for serial_frame_rx: a table of frames with expected outputs, hand
// sequences for timeout / reset / timeout-coincident edges (and parity when
// SERIAL_FRAME_PARITY_EN is defined), then randomized frames. A reference model
// that works on "pin samples seen SYNC_STAGES cycles late", "bits received"
// and "cycles since the last bit" is compared against the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;
  localparam int S = 2;
  localparam int T = 100;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FW = 18;
`else
  localparam int FW = 17;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sClk = 1'b0;
  logic        serialIn = 1'b0;
  logic [10:0] dataIn;
  logic [5:0]  dataInChange;
  logic        frame_valid;
  logic        frame_err;

  serial_frame_rx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .sClk         (sClk),
    .serialIn     (serialIn),
    .dataIn       (dataIn),
    .dataInChange (dataInChange),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          pin_c[$];
  bit          pin_d[$];
  int          m_nbits, m_word, m_idle;
  logic [10:0] e_data;
  logic [5:0]  e_chan;
  logic        e_valid, e_err;

  always @(posedge clk) begin
    bit now_c, prev_c, now_d;
    if (rst) begin
      pin_c = {};
      pin_d = {};
      repeat (S + 2) begin
        pin_c.push_back(1'b0);
        pin_d.push_back(1'b0);
      end
      m_nbits = 0; m_word = 0; m_idle = 0;
      e_data = '0; e_chan = '0; e_valid = 1'b0; e_err = 1'b0;
    end else begin
      pin_c.push_back(sClk);
      pin_d.push_back(serialIn);
      void'(pin_c.pop_front());
      void'(pin_d.pop_front());
      // Pins as the design sees them: sampled S clk edges ago, plus one older.
      now_c  = pin_c[1];
      prev_c = pin_c[0];
      now_d  = pin_d[1];
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (now_c && !prev_c) begin
        m_word = ((m_word << 1) | int'(now_d)) & ((1 << FW) - 1);
        m_nbits++;
        m_idle = 0;
        if (m_nbits == FW) begin
          m_nbits = 0;
`ifdef SERIAL_FRAME_PARITY_EN
          if (^m_word[FW-1:0]) e_err = 1'b1;
          else begin
            e_chan = m_word[16:11]; e_data = m_word[10:0]; e_valid = 1'b1;
          end
`else
          e_chan = m_word[16:11]; e_data = m_word[10:0]; e_valid = 1'b1;
`endif
        end
      end else if (m_nbits > 0) begin
        m_idle++;
        if (m_idle == T) begin
          e_err = 1'b1;
          m_nbits = 0;
          m_idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", {13'd0, e_valid, e_err, e_chan, e_data},
                     {13'd0, frame_valid, frame_err, dataInChange, dataIn});
      check("exclusive strobes", {31'd0, frame_valid & frame_err}, 32'd0);
      if (frame_valid) vcnt++;
      if (frame_err)   ecnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [17:0] mk_word(input logic [5:0] c, input logic [10:0] v, input bit flip);
    logic [16:0] p;
    p = {c, v};
    return {(^p) ^ flip, p};
  endfunction

  task automatic send_bit(input logic b, input int half, input bit junk);
    sClk = 1'b0;
    serialIn = b;
    tick(half);
    sClk = 1'b1;
    tick(1);
    if (junk) serialIn = 1'($urandom);
    if (half > 1) tick(half - 1);
  endtask

  // Sends the first nbits of a frame (MSB first); leaves sClk high.
  task automatic send_frame(input logic [5:0] c, input logic [10:0] v, input int half,
                            input int nbits, input bit flip, input bit junk);
    logic [17:0] w;
    w = mk_word(c, v, flip);
    for (int i = FW - 1; i >= FW - nbits; i--) send_bit(w[i], half, junk);
  endtask

  typedef struct {
    logic [5:0]  chan;
    logic [10:0] val;
    int          gap;
    logic [5:0]  exp_chan;
    logic [10:0] exp_val;
    int          exp_v;
    int          exp_e;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int v0, e0, k;
    logic [17:0] w;

    tbl[0] = '{6'd5,  11'd1500, 20, 6'd5,  11'd1500, 1, 0};
    tbl[1] = '{6'd63, 11'd2047, 0,  6'd63, 11'd2047, 1, 0};
    tbl[2] = '{6'd0,  11'd0,    20, 6'd0,  11'd0,    1, 0};
    tbl[3] = '{6'd33, 11'd1234, 10, 6'd33, 11'd1234, 1, 0};
    tbl[4] = '{6'd42, 11'd682,  0,  6'd42, 11'd682,  1, 0};
    tbl[5] = '{6'd21, 11'd1365, 10, 6'd21, 11'd1365, 1, 0};

    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset dataIn", dataIn, 0);
    check("reset dataInChange", dataInChange, 0);
    check("reset frame_valid", frame_valid, 0);
    check("reset frame_err", frame_err, 0);
    tick(3);

    // ---- table-driven frames ----
    for (int i = 0; i < 6; i++) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(tbl[i].chan, tbl[i].val, 4, FW, 1'b0, 1'b0);
      sClk = 1'b0;
      tick(tbl[i].gap);
      check($sformatf("row%0d chan", i), dataInChange, tbl[i].exp_chan);
      check($sformatf("row%0d data", i), dataIn, tbl[i].exp_val);
      check($sformatf("row%0d valid pulses", i), vcnt - v0, tbl[i].exp_v);
      check($sformatf("row%0d err pulses", i), ecnt - e0, tbl[i].exp_e);
    end
    tick(10);

    // ---- partial frame followed by silence: timeout ----
    v0 = vcnt; e0 = ecnt;
    send_frame(6'd9, 11'd321, 3, 8, 1'b0, 1'b0);
    sClk = 1'b0; serialIn = 1'b1;
    tick(3);
    sClk = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_err && k < 300);
    // 9th bit captured S+1 cycles after the pin rise, error T cycles after that.
    check("timeout latency", k, T + S + 2);
    tick(20);
    check("timeout err pulses", ecnt - e0, 1);
    check("timeout valid pulses", vcnt - v0, 0);
    check("timeout hold chan", dataInChange, tbl[5].exp_chan);
    check("timeout hold data", dataIn, tbl[5].exp_val);
    v0 = vcnt;
    send_frame(6'd12, 11'd777, 4, FW, 1'b0, 1'b0);
    sClk = 1'b0;
    tick(10);
    check("after timeout chan", dataInChange, 12);
    check("after timeout data", dataIn, 777);
    check("after timeout valid", vcnt - v0, 1);

    // ---- final bit edge lands exactly in the last timeout cycle ----
    v0 = vcnt; e0 = ecnt;
    w = mk_word(6'd20, 11'd999, 1'b0);
    send_frame(6'd20, 11'd999, 3, FW - 1, 1'b0, 1'b0);
    sClk = 1'b0; serialIn = w[0];
    tick(T - 3);
    sClk = 1'b1;
    tick(6);
    check("coincident valid", vcnt - v0, 1);
    check("coincident err", ecnt - e0, 0);
    check("coincident chan", dataInChange, 20);
    check("coincident data", dataIn, 999);
    sClk = 1'b0;
    tick(5);

    // ---- reset in the middle of a frame ----
    v0 = vcnt; e0 = ecnt;
    send_frame(6'd7, 11'd300, 3, 10, 1'b0, 1'b0);
    rst = 1'b1; sClk = 1'b0;
    tick(2);
    check("rst chan", dataInChange, 0);
    check("rst data", dataIn, 0);
    rst = 1'b0;
    tick(5);
    check("rst valid pulses", vcnt - v0, 0);
    check("rst err pulses", ecnt - e0, 0);
    send_frame(6'd1, 11'd1, 4, FW, 1'b0, 1'b0);
    sClk = 1'b0;
    tick(10);
    check("post-rst chan", dataInChange, 1);
    check("post-rst data", dataIn, 1);
    check("post-rst valid", vcnt - v0, 1);

`ifdef SERIAL_FRAME_PARITY_EN
    // ---- parity good / bad ----
    v0 = vcnt; e0 = ecnt;
    send_frame(6'd3, 11'd100, 4, FW, 1'b0, 1'b0);
    sClk = 1'b0;
    tick(10);
    check("parity ok valid", vcnt - v0, 1);
    check("parity ok chan", dataInChange, 3);
    check("parity ok data", dataIn, 100);
    v0 = vcnt; e0 = ecnt;
    send_frame(6'd3, 11'd100, 4, FW, 1'b1, 1'b0);
    sClk = 1'b0;
    tick(10);
    check("parity bad err", ecnt - e0, 1);
    check("parity bad valid", vcnt - v0, 0);
    check("parity bad hold chan", dataInChange, 3);
    check("parity bad hold data", dataIn, 100);
`endif

    // ---- randomized frames, checked cycle by cycle against the model ----
    for (int r = 0; r < 40; r++) begin
      logic [5:0]  c;
      logic [10:0] v;
      int          half, nb;
      c    = 6'($urandom);
      v    = 11'($urandom);
      half = $urandom_range(1, 5);
      nb   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, FW - 1) : FW;
      send_frame(c, v, half, nb, ($urandom_range(0, 5) == 0), 1'b1);
      sClk = 1'b0;
      if (nb < FW) tick($urandom_range(T - 3, T + 3));
      else         tick($urandom_range(0, 8));
    end
    sClk = 1'b0;
    tick(T + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
